mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 51 +++++
 rtl/mem_lsu_align.sv | 52 +++++
 rtl/mem_lsu.sv | 157 +++++++++++++++
 tb/tb_mem_lsu.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: aluop codes, FSM states,
// pipeline control constants and small op-classification helpers.
package mem_lsu_pkg;

    localparam logic RstEnable = 1'b0;
    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    function automatic logic is_load(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [7:0] op);
        return is_load(op) | is_store(op);
    endfunction

    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return |off;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational big-endian lane logic: store replication / byte enables
// and load lane selection with sign or zero extension.
module mem_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // offset 0 is the most significant byte
        case (off_i)
            2'd0:    byte_lane = rdata_i[31:24];
            2'd1:    byte_lane = rdata_i[23:16];
            2'd2:    byte_lane = rdata_i[15:8];
            default: byte_lane = rdata_i[7:0];
        endcase
        half_lane = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];

        case (op_i)
            OP_SB: begin
                sel_o   = 4'b1000 >> off_i;
                wdata_o = {4{sdata_i[7:0]}};
            end
            OP_SH: begin
                sel_o   = 4'b1100 >> off_i;
                wdata_o = {2{sdata_i[15:0]}};
            end
            default: begin
                sel_o   = 4'b1111;
                wdata_o = sdata_i;
            end
        endcase

        case (op_i)
            OP_LB:   ldata_o = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  ldata_o = {24'd0, byte_lane};
            OP_LH:   ldata_o = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  ldata_o = {16'd0, half_lane};
            default: ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: stalls the pipeline while a bus access is in
// flight, bounds the wait for ack, and flags misaligned or timed-out accesses.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter logic [7:0] WAIT_MAX = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [4:0]  write_addr_i,
    input  logic        write_en_i,
    input  logic [31:0] write_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic [4:0]  write_addr_o,
    output logic        write_en_o,
    output logic [31:0] write_data_o,
    output logic        stallreq_o,
    output logic        mem_err_o
);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  op_q;
    logic [1:0]  off_q;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  sel_q;

    logic        mem_op, misal, start, busy;
    logic [7:0]  al_op;
    logic [1:0]  al_off;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata, al_ldata;

    assign mem_op = is_mem_op(aluop_i);
    assign misal  = mem_op & misaligned(aluop_i, mem_addr_i[1:0]);
    assign start  = (state_q == S_IDLE) & mem_op & ~misal;
    assign busy   = (state_q == S_BUSY);

    // IDLE prepares the store lanes from live inputs; later states extend the captured load
    assign al_op  = (state_q == S_IDLE) ? aluop_i : op_q;
    assign al_off = (state_q == S_IDLE) ? mem_addr_i[1:0] : off_q;

    mem_align u_align (
        .op_i    (al_op),
        .off_i   (al_off),
        .sdata_i (mem_data_i),
        .rdata_i (rdata_q),
        .sel_o   (al_sel),
        .wdata_o (al_wdata),
        .ldata_o (al_ldata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            rdata_q   <= 32'd0;
            timeout_q <= 1'b0;
            op_q      <= OP_NOP;
            off_q     <= 2'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            sel_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
            if (start) begin
                op_q    <= aluop_i;
                off_q   <= mem_addr_i[1:0];
                we_q    <= is_store(aluop_i);
                addr_q  <= {mem_addr_i[31:2], 2'b00};
                wdata_q <= al_wdata;
                sel_q   <= al_sel;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        timeout_d    = timeout_q;
        bus_req_o    = 1'b0;
        stallreq_o   = NO_STOP;
        mem_err_o    = 1'b0;
        write_addr_o = write_addr_i;
        write_en_o   = write_en_i;
        write_data_o = write_data_i;

        case (state_q)
            S_IDLE: begin
                if (misal) begin
                    mem_err_o  = 1'b1;
                    write_en_o = 1'b0;
                end else if (mem_op) begin
                    stallreq_o = STOP;
                    write_en_o = 1'b0;
                    cnt_d      = 8'd0;
                    timeout_d  = 1'b0;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                bus_req_o  = 1'b1;
                stallreq_o = STOP;
                write_en_o = 1'b0;
                if (bus_ack_i) begin
                    rdata_d = bus_rdata_i;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == WAIT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                mem_err_o  = timeout_q;
                write_en_o = write_en_i & is_load(op_q) & ~timeout_q;
                if (is_load(op_q))
                    write_data_o = al_ldata;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // combinational requests must vanish the moment reset is applied
        if (rst == RstEnable) begin
            bus_req_o  = 1'b0;
            stallreq_o = NO_STOP;
            mem_err_o  = 1'b0;
            write_en_o = 1'b0;
        end
    end

    assign bus_we_o    = busy & we_q;
    assign bus_sel_o   = busy ? sel_q : 4'd0;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a transaction-level model predicts every
// output per cycle; literal checks pin the headline scenarios.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int WMAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  aluop_i = OP_NOP;
    logic [31:0] mem_addr_i = '0, mem_data_i = '0;
    logic [4:0]  write_addr_i = '0;
    logic        write_en_i = 1'b0;
    logic [31:0] write_data_i = '0;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;
    logic [4:0]  write_addr_o;
    logic        write_en_o;
    logic [31:0] write_data_o;
    logic        stallreq_o, mem_err_o;

    mem_lsu #(.WAIT_MAX(8'd4)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i), .write_addr_i(write_addr_i),
        .write_en_i(write_en_i), .write_data_i(write_data_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .write_addr_o(write_addr_o), .write_en_o(write_en_o),
        .write_data_o(write_data_o), .stallreq_o(stallreq_o),
        .mem_err_o(mem_err_o)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- transaction model ----------------
    logic [7:0]  m_op;
    logic [31:0] m_addr, m_sdata, m_rdata, m_wd;
    logic [4:0]  m_wa;
    logic        m_we;
    int          m_ack_k;   // ack in the (k+1)th request cycle; -1 = never
    int          cyc;
    bit          chk_en = 1'b0;

    int stall_tot = 0, req_tot = 0, err_tot = 0, wen_tot = 0;
    logic [31:0] last_wd, last_bwd, last_sel;
    logic        last_bwe;

    function automatic bit op_mem(input logic [7:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    endfunction
    function automatic bit op_load(input logic [7:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction
    function automatic int op_size(input logic [7:0] op);
        if (op == OP_LW || op == OP_SW) return 4;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 1;
    endfunction
    function automatic bit op_mis(input logic [7:0] op, input logic [31:0] a);
        return op_mem(op) && ((int'(a[1:0]) % op_size(op)) != 0);
    endfunction
    function automatic bit op_tmo(input int k);
        return (k < 0) || (k >= WMAX);
    endfunction
    function automatic int op_len(input logic [7:0] op, input logic [31:0] a, input int k);
        if (!op_mem(op) || op_mis(op, a)) return 1;
        return op_tmo(k) ? WMAX + 2 : k + 3;
    endfunction
    function automatic logic [31:0] exp_load(input logic [7:0] op, input int o, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (3 - o))) & 32'hFF;
        h = (w >> (16 * (1 - o / 2))) & 32'hFFFF;
        case (op)
            OP_LB:   return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            OP_LHU:  return h;
            default: return w;
        endcase
    endfunction
    function automatic logic [31:0] exp_sel(input logic [7:0] op, input int o);
        if (op == OP_SB) return 32'd1 << (3 - o);
        if (op == OP_SH) return 32'd3 << (2 - o);
        return 32'd15;
    endfunction
    function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] d);
        if (op == OP_SB) return (d & 32'hFF) * 32'h01010101;
        if (op == OP_SH) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    always @(negedge clk) begin : cmp
        int o, busy_end;
        bit tmo, ld;
        if (chk_en) begin
            stall_tot += stallreq_o ? 1 : 0;
            req_tot   += bus_req_o ? 1 : 0;
            err_tot   += mem_err_o ? 1 : 0;
            wen_tot   += write_en_o ? 1 : 0;
            if (bus_req_o) begin
                last_sel = 32'(bus_sel_o); last_bwd = bus_wdata_o; last_bwe = bus_we_o;
            end
            if (write_en_o) last_wd = write_data_o;

            o  = int'(m_addr[1:0]);
            ld = op_load(m_op);
            if (!op_mem(m_op)) begin
                check("pass_wa",    32'(write_addr_o), 32'(m_wa));
                check("pass_we",    32'(write_en_o),   32'(m_we));
                check("pass_wd",    write_data_o,      m_wd);
                check("pass_req",   32'(bus_req_o),    0);
                check("pass_stall", 32'(stallreq_o),   0);
            end else if (op_mis(m_op, m_addr)) begin
                check("mis_req",   32'(bus_req_o),  0);
                check("mis_stall", 32'(stallreq_o), 0);
                check("mis_err",   32'(mem_err_o),  1);
                check("mis_wen",   32'(write_en_o), 0);
            end else begin
                tmo      = op_tmo(m_ack_k);
                busy_end = tmo ? WMAX : m_ack_k + 1;
                if (cyc == 0) begin
                    check("idle_stall", 32'(stallreq_o), 1);
                    check("idle_req",   32'(bus_req_o),  0);
                    check("idle_wen",   32'(write_en_o), 0);
                    check("idle_err",   32'(mem_err_o),  0);
                end else if (cyc <= busy_end) begin
                    check("busy_req",   32'(bus_req_o),  1);
                    check("busy_stall", 32'(stallreq_o), 1);
                    check("busy_wen",   32'(write_en_o), 0);
                    check("busy_err",   32'(mem_err_o),  0);
                    check("busy_we",    32'(bus_we_o),   ld ? 0 : 1);
                    check("busy_addr",  bus_addr_o,      m_addr & 32'hFFFFFFFC);
                    check("busy_sel",   32'(bus_sel_o),  exp_sel(m_op, o));
                    if (!ld) check("busy_wdata", bus_wdata_o, exp_wdata(m_op, m_sdata));
                end else begin
                    check("done_req",   32'(bus_req_o),  0);
                    check("done_stall", 32'(stallreq_o), 0);
                    check("done_err",   32'(mem_err_o),  tmo ? 1 : 0);
                    check("done_wen",   32'(write_en_o), (ld && m_we && !tmo) ? 1 : 0);
                    if (ld && !tmo) begin
                        check("done_wa", 32'(write_addr_o), 32'(m_wa));
                        check("done_wd", write_data_o, exp_load(m_op, o, m_rdata));
                    end
                end
            end
        end
    end

    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int ack_k, input bit stray);
        int len;
        aluop_i = op; mem_addr_i = addr; mem_data_i = sdata; bus_rdata_i = rdata;
        write_addr_i = 5'd7; write_en_i = 1'b1; write_data_i = 32'h55550000 ^ addr;
        m_op = op; m_addr = addr; m_sdata = sdata; m_rdata = rdata; m_ack_k = ack_k;
        m_wa = 5'd7; m_we = 1'b1; m_wd = 32'h55550000 ^ addr;
        len = op_len(op, addr, ack_k);
        chk_en = 1'b1;
        for (int c = 0; c < len; c++) begin
            cyc = c;
            bus_ack_i = (stray && c == 0) || (ack_k >= 0 && c == ack_k + 1);
            @(posedge clk); #1;
        end
        chk_en = 1'b0; bus_ack_i = 1'b0; aluop_i = OP_NOP;
    endtask

    int s0, r0, e0, w0;
    task automatic snap();
        s0 = stall_tot; r0 = req_tot; e0 = err_tot; w0 = wen_tot;
    endtask

    initial begin
        // reset state with an aligned load already presented
        aluop_i = OP_LW; mem_addr_i = 32'h100; write_en_i = 1'b1; bus_ack_i = 1'b1;
        #3;
        check("rst_req",   32'(bus_req_o),  0);
        check("rst_stall", 32'(stallreq_o), 0);
        check("rst_err",   32'(mem_err_o),  0);
        check("rst_wen",   32'(write_en_o), 0);
        check("rst_we",    32'(bus_we_o),   0);
        check("rst_sel",   32'(bus_sel_o),  0);
        aluop_i = OP_NOP; bus_ack_i = 1'b0;
        #10 rst = 1'b1;
        @(posedge clk); #1;

        run_op(OP_NOP, 32'h0000_0040, 0, 0, -1, 0);

        snap(); run_op(OP_LW, 32'h100, 0, 32'hDEADBEEF, 0, 0);
        check("lw_wd",    last_wd, 32'hDEADBEEF);
        check("lw_stall", 32'(stall_tot - s0), 2);

        run_op(OP_LB, 32'h103, 0, 32'h123456F0, 0, 0);
        check("lb_wd", last_wd, 32'hFFFFFFF0);
        run_op(OP_LBU, 32'h103, 0, 32'h123456F0, 1, 0);
        check("lbu_wd", last_wd, 32'h000000F0);
        run_op(OP_LH, 32'h102, 0, 32'h12348001, 0, 0);
        check("lh_wd", last_wd, 32'hFFFF8001);
        run_op(OP_LHU, 32'h100, 0, 32'h80011234, 2, 0);
        check("lhu_wd", last_wd, 32'h00008001);
        run_op(OP_LB, 32'h101, 0, 32'h127F5634, 0, 0);
        check("lb1_wd", last_wd, 32'h0000007F);

        snap(); run_op(OP_SH, 32'h202, 32'h0000ABCD, 0, 1, 0);
        check("sh_sel", last_sel, 32'h3);
        check("sh_bwd", last_bwd, 32'hABCDABCD);
        check("sh_bwe", 32'(last_bwe), 1);
        check("sh_wen", 32'(wen_tot - w0), 0);
        run_op(OP_SB, 32'h301, 32'h1234565A, 0, 0, 0);
        check("sb_sel", last_sel, 32'h4);
        check("sb_bwd", last_bwd, 32'h5A5A5A5A);
        run_op(OP_SW, 32'h400, 32'h11223344, 0, 0, 0);

        snap(); run_op(OP_LW, 32'h101, 0, 32'hFFFFFFFF, 0, 0);
        check("mis_reqs", 32'(req_tot - r0), 0);
        check("mis_errs", 32'(err_tot - e0), 1);
        check("mis_stl",  32'(stall_tot - s0), 0);
        run_op(OP_SH, 32'h203, 32'h1, 0, 0, 0);

        // ack arriving while idle must not shortcut the access
        run_op(OP_LW, 32'h500, 0, 32'h0BADF00D, 1, 1);

        snap(); run_op(OP_LW, 32'h104, 0, 32'h77777777, -1, 0);
        check("tmo_reqs", 32'(req_tot - r0), 4);
        check("tmo_errs", 32'(err_tot - e0), 1);
        check("tmo_wen",  32'(wen_tot - w0), 0);

        snap(); run_op(OP_LW, 32'h108, 0, 32'hCAFEF00D, 3, 0);
        check("late_reqs", 32'(req_tot - r0), 4);
        check("late_errs", 32'(err_tot - e0), 0);
        check("late_wd",   last_wd, 32'hCAFEF00D);

        // reset in the middle of a bus access
        aluop_i = OP_LW; mem_addr_i = 32'h600; bus_ack_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_req", 32'(bus_req_o), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_req",   32'(bus_req_o),  0);
        check("arst_stall", 32'(stallreq_o), 0);
        check("arst_sel",   32'(bus_sel_o),  0);
        aluop_i = OP_NOP;
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        check("no_replay", 32'(bus_req_o), 0);
        run_op(OP_NOP, 32'h0, 0, 0, -1, 0);
        run_op(OP_LW, 32'h700, 0, 32'h13579BDF, 0, 0);
        check("post_rst_wd", last_wd, 32'h13579BDF);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
